// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared types and constants for the instruction/data memory port
//            arbiter: line/word geometry, beat-index width, FSM encoding.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int LINE_W = 128;
  localparam int MEM_W  = 32;
  localparam int BEATS  = LINE_W / MEM_W;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_XFER = 2'd1,
    DC_XFER = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_line_beat_buf.sv
`default_nettype none
// ============================================================================
// Module   : line_beat_buf
// Purpose  : BEATS x MEM_W line buffer. Loaded in parallel with a write line
//            at grant, captures read words one beat at a time, offers the
//            word selected by the beat index, and exposes the whole line.
// Ports    : clk, reset (async, active-low)
//            load / load_line   - parallel load of a full line
//            cap / idx / cap_word - write one word at beat index idx
//            sel_word           - word[idx] (write-data mux)
//            line               - full line, word k at bits [32k+31:32k]
// Revision : 1.0 - initial release
// ============================================================================
module line_beat_buf
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              cap,
  input  logic [BEAT_W-1:0] idx,
  input  logic [MEM_W-1:0]  cap_word,
  output logic [MEM_W-1:0]  sel_word,
  output logic [LINE_W-1:0] line
);

  generate
    for (genvar k = 0; k < BEATS; k++) begin : g_word
      logic [MEM_W-1:0] word_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_q <= '0;
        end else if (load) begin
          word_q <= load_line[k*MEM_W +: MEM_W];
        end else if (cap && (idx == BEAT_W'(k))) begin
          word_q <= cap_word;
        end
      end

      assign line[k*MEM_W +: MEM_W] = word_q;
    end
  endgenerate

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (idx == BEAT_W'(k)) begin
        sel_word = line[k*MEM_W +: MEM_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares one 32-bit memory port between icache line refills and
//            dcache line reads/writes. Each line becomes a 4-beat word burst;
//            read words are reassembled and returned with a 1-cycle pulse.
//            dcache has priority; icache is granted after STARVE_MAX
//            consecutive dcache wins. icache may abort an in-flight refill.
// Ports    : clk, reset (async, active-low)
//            ic_req/ic_addr/ic_abort -> ic_rdata/ic_rvalid
//            dc_req/dc_we/dc_addr/dc_wdata -> dc_rdata/dc_done
//            mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int LINE_W     = 128,
  parameter int MEM_W      = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  input  logic              ic_abort,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [31:0]       dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_ack
);

  import imem_pkg::*;

  localparam int                SC_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [SC_W-1:0]     starve_cnt, starve_nxt;
  logic                abort_pend, abort_nxt;
  logic [31:0]         base;
  logic                we_q;
  logic                grant_ic, grant_dc;
  logic                ic_fin, dc_fin;
  logic                ic_ok;
  logic                xfer;
  logic [31:0]         beat_off;
  logic [MEM_W-1:0]    sel_word;
  logic [LINE_W-1:0]   line_buf;
  logic [LINE_W-1:0]   fin_line;
  logic                unused_addr_bits;

  // An icache request raised together with its own abort is withdrawn.
  assign ic_ok = ic_req && !ic_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= '0;
      starve_cnt <= '0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat       <= beat_nxt;
      starve_cnt <= starve_nxt;
      abort_pend <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    starve_nxt = starve_cnt;
    abort_nxt  = abort_pend;
    grant_ic   = 1'b0;
    grant_dc   = 1'b0;
    ic_fin     = 1'b0;
    dc_fin     = 1'b0;
    case (state)
      IDLE: begin
        if (dc_req && (!ic_ok || (starve_cnt < STARVE_LIM))) begin
          grant_dc  = 1'b1;
          state_nxt = DC_XFER;
          beat_nxt  = '0;
          if (ic_ok) begin
            starve_nxt = starve_cnt + SC_W'(1);
          end
        end else if (ic_ok) begin
          grant_ic   = 1'b1;
          state_nxt  = IC_XFER;
          beat_nxt   = '0;
          starve_nxt = '0;
        end
      end
      IC_XFER: begin
        if (ic_abort) begin
          abort_nxt = 1'b1;
        end
        if (mem_ack) begin
          beat_nxt = beat + BEAT_W'(1);
          // An abort (pending or arriving now) ends the burst on this ack.
          if ((beat == LAST_BEAT) || abort_pend || ic_abort) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            abort_nxt = 1'b0;
            ic_fin    = (beat == LAST_BEAT) && !abort_pend && !ic_abort;
          end
        end
      end
      DC_XFER: begin
        if (mem_ack) begin
          beat_nxt = beat + BEAT_W'(1);
          if (beat == LAST_BEAT) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            dc_fin    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base      <= '0;
      we_q      <= 1'b0;
      ic_rvalid <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      if (grant_dc) begin
        base <= {dc_addr[31:4], 4'h0};
        we_q <= dc_we;
      end else if (grant_ic) begin
        base <= {ic_addr[31:4], 4'h0};
        we_q <= 1'b0;
      end
      ic_rvalid <= ic_fin;
      dc_done   <= dc_fin;
      if (ic_fin) begin
        ic_rdata <= fin_line;
      end
      if (dc_fin && !we_q) begin
        dc_rdata <= fin_line;
      end
    end
  end

  line_beat_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (grant_dc),
    .load_line (dc_wdata),
    .cap       (xfer && mem_ack && !we_q),
    .idx       (beat),
    .cap_word  (mem_rdata),
    .sel_word  (sel_word),
    .line      (line_buf)
  );

  // The final word arrives on the same edge the response is registered, so
  // it bypasses the buffer to keep the pulse one cycle after the last ack.
  assign fin_line = {mem_rdata, line_buf[LINE_W-MEM_W-1:0]};

  assign xfer      = (state != IDLE);
  assign beat_off  = {{(32-BEAT_W-2){1'b0}}, beat, 2'b00};
  assign mem_req   = xfer;
  assign mem_we    = xfer && we_q;
  assign mem_addr  = xfer ? (base + beat_off) : 32'h0;
  assign mem_wdata = (xfer && we_q) ? sel_word : '0;

  assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[3:0]};

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Self-checking bench for imem_arbiter. A memory responder with a
//            programmable ack delay checks every beat against a queue of
//            expected beats; a response monitor checks every pulse against a
//            queue of expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ic_req = 1'b0, ic_abort = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic [127:0] ic_rdata;
  logic         ic_rvalid;
  logic         dc_req = 1'b0, dc_we = 1'b0;
  logic [31:0]  dc_addr = '0;
  logic [127:0] dc_wdata = '0;
  logic [127:0] dc_rdata;
  logic         dc_done;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_ack = 1'b0;

  always #5 clk = ~clk;

  imem_arbiter #(.LINE_W(128), .MEM_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_abort(ic_abort),
    .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} beat_t;
  typedef struct {bit is_ic; bit chk_data; logic [127:0] data;} resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];
  int n_tests = 0, n_fail = 0;
  int ack_delay = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides ack for the coming edge at each negedge.
  int wait_cnt = 0;
  bit pending = 0;
  always @(negedge clk) begin : mem_model
    beat_t e;
    if (!reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      pending  = 0;
    end else begin
      if (pending) chk("mem_req_held", mem_req, 1'b1);
      pending = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
        n_tests++;
        assert (beat_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed addr %h expected no request", mem_addr);
        end
        if (beat_q.size() != 0) begin
          e = beat_q[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", mem_we, e.we);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          if (wait_cnt >= ack_delay) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            void'(beat_q.pop_front());
            if (!e.we) begin
              if (rd_q.size() != 0) mem_rdata = rd_q.pop_front();
              else mem_rdata = 32'hDEAD_BEEF;
            end
          end else begin
            wait_cnt++;
            pending = 1;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin : resp_mon
    resp_t r;
    if (reset && (ic_rvalid || dc_done)) begin
      n_tests++;
      assert (resp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_resp: observed ic_rvalid=%b dc_done=%b expected no pulse",
               ic_rvalid, dc_done);
      end
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        chk("resp_ic_rvalid", ic_rvalid, r.is_ic);
        chk("resp_dc_done", dc_done, !r.is_ic);
        if (r.chk_data) chk("resp_data", r.is_ic ? ic_rdata : dc_rdata, r.data);
      end
    end
  end

  task automatic push_beats(input logic [31:0] addr, input logic [31:0] w0, input int n);
    beat_t b;
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    for (int k = 0; k < n; k++) begin
      b.addr = base + 32'(4*k); b.we = 1'b0; b.wdata = '0;
      beat_q.push_back(b);
      rd_q.push_back(w0 + 32'(k));
    end
  endtask

  task automatic push_read(input bit is_ic, input logic [31:0] addr, input logic [31:0] w0);
    resp_t r;
    push_beats(addr, w0, 4);
    r.is_ic = is_ic; r.chk_data = 1'b1; r.data = '0;
    for (int k = 0; k < 4; k++) r.data[32*k +: 32] = w0 + 32'(k);
    resp_q.push_back(r);
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [127:0] line);
    beat_t b;
    resp_t r;
    for (int k = 0; k < 4; k++) begin
      b.addr = {addr[31:4], 4'h0} + 32'(4*k); b.we = 1'b1; b.wdata = line[32*k +: 32];
      beat_q.push_back(b);
    end
    r.is_ic = 1'b0; r.chk_data = 1'b0; r.data = '0;
    resp_q.push_back(r);
  endtask

  task automatic wait_pulse(input bit want_ic, input int max_cyc, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(want_ic ? ic_rvalid : dc_done) && n < max_cyc);
    chk(tag, want_ic ? ic_rvalid : dc_done, 1'b1);
  endtask

  task automatic wait_addr(input logic [31:0] a, input int max_cyc, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(mem_req && mem_addr == a) && n < max_cyc);
    chk(tag, {mem_req, mem_addr}, {1'b1, a});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t0, nd, ni, guard;
    logic [127:0] wline;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ic_rvalid", ic_rvalid, 1'b0);
    chk("rst_dc_done", dc_done, 1'b0);
    chk("rst_ic_rdata", ic_rdata, 128'h0);
    chk("rst_dc_rdata", dc_rdata, 128'h0);
    @(posedge clk); #1 reset = 1'b1;

    // 1: icache refill, zero-wait memory, latency and line assembly.
    ack_delay = 0;
    push_read(1'b1, 32'h0000_1234, 32'hA0);
    idle(1);
    ic_req = 1'b1; ic_addr = 32'h0000_1234; t0 = cyc;
    wait_pulse(1'b1, 20, "t1_rvalid");
    ic_req = 1'b0;
    chk("t1_latency", cyc - t0, 5);
    chk("t1_rdata", ic_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
    idle(2);

    // 2: dcache line write with 2-cycle ack delay per beat.
    ack_delay = 2;
    wline = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    push_write(32'h0000_0040, wline);
    idle(1);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0040; dc_wdata = wline;
    wait_pulse(1'b0, 60, "t2_done");
    dc_req = 1'b0; dc_we = 1'b0;
    idle(3);
    chk("t2_beats_drained", beat_q.size(), 0);

    // 3: both requesting continuously -> D,D,D,I,D,D,D,I.
    ack_delay = 0;
    for (int g = 0; g < 2; g++) begin
      for (int d = 0; d < 3; d++) push_read(1'b0, 32'h0000_0200, 32'hD000_0000 + 32'(16*(3*g+d)));
      push_read(1'b1, 32'h0000_0300, 32'hC000_0000 + 32'(16*g));
    end
    idle(1);
    dc_addr = 32'h0000_0200; ic_addr = 32'h0000_0300;
    dc_req = 1'b1; ic_req = 1'b1;
    nd = 0; ni = 0; guard = 0;
    while ((nd + ni) < 8 && guard < 300) begin
      @(negedge clk); guard++;
      if (dc_done) begin nd++; if (nd == 6) dc_req = 1'b0; end
      if (ic_rvalid) begin ni++; if (ni == 2) ic_req = 1'b0; end
    end
    dc_req = 1'b0; ic_req = 1'b0;
    chk("t3_dc_grants", nd, 6);
    chk("t3_ic_grants", ni, 2);
    idle(2);

    // 4: abort during beat 1 with stalled acks; dcache granted right after.
    ack_delay = 3;
    push_beats(32'h0000_0500, 32'h50, 2);
    push_read(1'b0, 32'h0000_0600, 32'hE0);
    idle(1);
    ic_req = 1'b1; ic_addr = 32'h0000_0500;
    wait_addr(32'h0000_0504, 40, "t4_beat1");
    @(posedge clk); #1;
    ic_abort = 1'b1; ic_req = 1'b0;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0600;
    @(posedge clk); #1 ic_abort = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (mem_req && guard < 20);
    chk("t4_idle_gap", mem_req, 1'b0);
    @(negedge clk);
    chk("t4_dc_granted", {mem_req, mem_addr}, {1'b1, 32'h0000_0600});
    wait_pulse(1'b0, 60, "t4_dc_done");
    dc_req = 1'b0;
    idle(2);

    // 5: abort coincident with the final beat's ack.
    ack_delay = 0;
    push_beats(32'h0000_0900, 32'h90, 4);
    idle(1);
    ic_req = 1'b1; ic_addr = 32'h0000_0900;
    repeat (4) @(posedge clk);
    #1 ic_abort = 1'b1;
    @(posedge clk); #1 ic_abort = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    chk("t5_no_rvalid", ic_rvalid, 1'b0);
    chk("t5_idle", mem_req, 1'b0);
    idle(3);
    chk("t5_beats_drained", beat_q.size(), 0);

    // 6: reset during dcache beat 2, then a fresh request.
    ack_delay = 1;
    push_read(1'b0, 32'h0000_0700, 32'h70);
    idle(1);
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0700;
    wait_addr(32'h0000_0708, 40, "t6_beat2");
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req", mem_req, 1'b0);
    chk("t6_async_addr", mem_addr, 32'h0);
    dc_req = 1'b0;
    beat_q.delete(); rd_q.delete(); resp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_idle_req", mem_req, 1'b0);
    chk("t6_no_done", dc_done, 1'b0);
    chk("t6_dc_rdata_rst", dc_rdata, 128'h0);
    push_read(1'b0, 32'hFFFF_FFF0, 32'hF0);
    @(posedge clk); #1;
    dc_req = 1'b1; dc_addr = 32'hFFFF_FFF0;
    wait_pulse(1'b0, 40, "t6_fresh_done");
    dc_req = 1'b0;
    chk("t6_fresh_rdata", dc_rdata, 128'h000000F3_000000F2_000000F1_000000F0);
    idle(3);

    chk("end_beats_empty", beat_q.size(), 0);
    chk("end_resp_empty", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
